fir_inverse_iir: RTL and testbench



---
 rtl/dsp_filters_pkg.sv | 35 +++
 rtl/dsp_mac_step.sv | 25 ++
 rtl/fir_inverse_iir.sv | 124 ++++++++++++
 tb/tb_fir_inverse_iir.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_filters_pkg.sv
// Shared types, defaults and arithmetic helpers for the DSP filter blocks.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package dsp_filters_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MAC  = 2'd1,
        S_OUT  = 2'd2
    } state_e;

    // Monic default taps h[0..3]; h[0] is implied by the recursion and never multiplied.
    localparam logic signed [15:0] DEFAULT_COEFFS [4] = '{16'sd1, 16'sd2, 16'sd3, 16'sd4};

    // Accumulator width: full product plus growth for N-1 accumulations and a guard bit.
    function automatic int acc_width(input int dw, input int cw, input int n);
        return dw + cw + $clog2(n) + 1;
    endfunction

    // Clamp a signed value to the range representable in 'width' bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] value,
                                                      input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (value > max_v) begin
            return max_v;
        end else if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/dsp_mac_step.sv
// One multiply-subtract step: acc_o = acc_i - coeff_i * sample_i at accumulator width.
// Latency: combinational.
// Backpressure: none; pure datapath.
module dsp_mac_step #(
    parameter int ACC_WIDTH   = 35,
    parameter int COEFF_WIDTH = 16,
    parameter int DATA_WIDTH  = 16
) (
    input  logic signed [ACC_WIDTH-1:0]   acc_i,
    input  logic signed [COEFF_WIDTH-1:0] coeff_i,
    input  logic signed [DATA_WIDTH-1:0]  sample_i,
    output logic signed [ACC_WIDTH-1:0]   acc_o
);

    logic signed [ACC_WIDTH-1:0] coeff_ext;
    logic signed [ACC_WIDTH-1:0] sample_ext;
    logic signed [ACC_WIDTH-1:0] prod;

    // Both operands are sign-extended first so the product never overflows the accumulator.
    assign coeff_ext  = ACC_WIDTH'(coeff_i);
    assign sample_ext = ACC_WIDTH'(sample_i);
    assign prod       = coeff_ext * sample_ext;
    assign acc_o      = acc_i - prod;

endmodule

// File: rtl/fir_inverse_iir.sv
// Inverse of a monic FIR: y[n] = x[n] - sum_{k=1..N-1} h[k]*y[n-k], one tap per cycle.
// Latency: out_valid rises N cycles after the input handshake cycle; one sample per N+1 cycles.
// Backpressure: no skid buffer; in_ready stays low until the held output is taken.
module fir_inverse_iir
    import dsp_filters_pkg::*;
#(
    parameter int N           = 4,
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter logic signed [COEFF_WIDTH-1:0] COEFFS [N] = DEFAULT_COEFFS
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [DATA_WIDTH-1:0] y_out,
    input  logic                         clear
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, N);
    localparam int IDX_W     = $clog2(N);

    state_e                        state_q, state_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic        [IDX_W-1:0]       idx_q, idx_d;
    logic signed [DATA_WIDTH-1:0]  y_hist_q [N-1];
    logic signed [DATA_WIDTH-1:0]  y_hist_d [N-1];
    logic signed [DATA_WIDTH-1:0]  y_out_q, y_out_d;
    logic                          in_ready_q;

    logic        [IDX_W-1:0]       hist_sel;
    logic signed [COEFF_WIDTH-1:0] coeff_sel;
    logic signed [ACC_WIDTH-1:0]   mac_res;
    logic signed [DATA_WIDTH-1:0]  mac_sat;

    // idx runs 1..N-1 in S_MAC; tap idx pairs with y[n-idx], stored at history slot idx-1.
    assign hist_sel  = idx_q - IDX_W'(1);
    assign coeff_sel = COEFFS[idx_q];
    assign mac_sat   = DATA_WIDTH'(sat_signed(64'(mac_res), DATA_WIDTH));

    dsp_mac_step #(
        .ACC_WIDTH  (ACC_WIDTH),
        .COEFF_WIDTH(COEFF_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .acc_i   (acc_q),
        .coeff_i (coeff_sel),
        .sample_i(y_hist_q[hist_sel]),
        .acc_o   (mac_res)
    );

    assign in_ready  = in_ready_q;
    assign out_valid = (state_q == S_OUT);
    assign y_out     = y_out_q;

    // Next-state logic: accept in idle, accumulate one tap per cycle, hold result until taken.
    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        idx_d    = idx_q;
        y_hist_d = y_hist_q;
        y_out_d  = y_out_q;
        case (state_q)
            S_IDLE: begin
                // A flush coinciding with a handshake still leaves the new sample zero history.
                if (clear) begin
                    for (int k = 0; k < N - 1; k++) begin
                        y_hist_d[k] = '0;
                    end
                end
                if (in_valid && in_ready_q) begin
                    acc_d   = ACC_WIDTH'(x_in);
                    idx_d   = IDX_W'(1);
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = mac_res;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(N - 1)) begin
                    y_out_d = mac_sat;
                    state_d = S_OUT;
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    y_hist_d[0] = y_out_q;
                    for (int k = 1; k < N - 1; k++) begin
                        y_hist_d[k] = y_hist_q[k-1];
                    end
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any partial sample and the history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            y_out_q    <= '0;
            in_ready_q <= 1'b0;
            for (int k = 0; k < N - 1; k++) begin
                y_hist_q[k] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            y_out_q    <= y_out_d;
            in_ready_q <= (state_d == S_IDLE);
            y_hist_q   <= y_hist_d;
        end
    end

endmodule

// File: tb/tb_fir_inverse_iir.sv
// Directed and table-driven bench for fir_inverse_iir with default taps {1,2,3,4}.
// Inputs are driven and outputs sampled on the falling clock edge.
// Random back-to-back traffic is checked against a saturating golden recursion.
module tb_fir_inverse_iir;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic signed [15:0] x_in;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] y_out;
    logic               clear;

    int errors = 0;
    int checks = 0;

    fir_inverse_iir dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .x_in     (x_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .y_out    (y_out),
        .clear    (clear)
    );

    // clr: 0 = none, 1 = clear cycle in idle before the sample, 2 = clear with the handshake
    typedef struct {
        logic signed [15:0] x;
        logic signed [15:0] y;
        int                 clr;
    } vec_t;

    vec_t tbl [13];

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        clear     = 1'b0;
        x_in      = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Handshake one sample and return the first output with its latency in cycles.
    task automatic send_sample(input logic signed [15:0] x, input int clr,
                               output logic signed [15:0] y, output int lat);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("in_ready_timeout", 0, 1);
        if (clr == 1) begin
            clear = 1'b1;
            @(negedge clk);
            clear = 1'b0;
        end
        in_valid = 1'b1;
        x_in     = x;
        clear    = (clr == 2);
        @(negedge clk);
        in_valid = 1'b0;
        clear    = 1'b0;
        x_in     = 16'sh1234;
        lat = 1;
        while (!out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        y = y_out;
    endtask

    function automatic longint sat16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    initial begin
        logic signed [15:0] y;
        int                 lat;
        int                 stable;
        int                 t_first, t_second, accepts, cyc;
        logic signed [15:0] samples [20];
        longint             gold [20];
        longint             h1, h2, h3, v;
        int                 sent, recv, overlap, guard;

        tbl[0]  = '{16'sd1,     16'sd1,      0};
        tbl[1]  = '{16'sd2,     16'sd0,      0};
        tbl[2]  = '{16'sd3,     16'sd0,      0};
        tbl[3]  = '{16'sd4,     16'sd0,      0};
        tbl[4]  = '{16'sd0,     16'sd0,      0};
        tbl[5]  = '{16'sd0,     16'sd0,      0};
        tbl[6]  = '{16'sd30000, 16'sd30000,  0};
        tbl[7]  = '{16'sd0,     -16'sd32768, 0};
        tbl[8]  = '{16'sd0,     -16'sd24464, 0};
        tbl[9]  = '{16'sd5,     16'sd27237,  0};
        tbl[10] = '{16'sd3,     16'sd3,      1};
        tbl[11] = '{16'sd1,     -16'sd5,     0};
        tbl[12] = '{16'sd2,     16'sd2,      2};

        // Reset state while rst_n is held low
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0; x_in = '0; out_ready = 1'b0;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_y_out", y_out, 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", in_ready, 1);

        // Table: impulse deconvolution, saturation, clear before / with handshake
        out_ready = 1'b1;
        for (int i = 0; i < 13; i++) begin
            send_sample(tbl[i].x, tbl[i].clr, y, lat);
            check($sformatf("tbl%0d_y", i), y, tbl[i].y);
            check($sformatf("tbl%0d_latency", i), lat, 4);
        end

        // Backpressure: output held stable with in_ready low
        do_reset();
        out_ready = 1'b0;
        send_sample(16'sd7, 0, y, lat);
        check("bp_y", y, 7);
        stable = 1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (!(out_valid === 1'b1 && y_out === 16'sd7 && in_ready === 1'b0)) stable = 0;
        end
        check("bp_hold_stable", stable, 1);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_out_valid", out_valid, 0);
        check("bp_release_in_ready", in_ready, 1);
        send_sample(16'sd0, 0, y, lat);
        check("bp_next_y", y, -14);

        // Reset during the MAC phase
        in_valid = 1'b1; x_in = 16'sd5;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_y_out", y_out, 0);
        check("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_in_ready_after", in_ready, 1);
        send_sample(16'sd9, 0, y, lat);
        check("midrst_y", y, 9);
        check("midrst_latency", lat, 4);

        // Throughput: N+1 cycles per sample with both sides always willing
        @(negedge clk);
        in_valid = 1'b1; x_in = 16'sd0;
        accepts = 0; t_first = 0; t_second = 0; cyc = 0;
        while (accepts < 2 && cyc < 40) begin
            if (in_ready) begin
                if (accepts == 0) t_first = cyc; else t_second = cyc;
                accepts++;
            end
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("throughput_period", t_second - t_first, 5);
        repeat (10) @(negedge clk);

        // Back-to-back random traffic against the golden recursion
        do_reset();
        h1 = 0; h2 = 0; h3 = 0;
        for (int i = 0; i < 20; i++) begin
            samples[i] = 16'($urandom_range(0, 65535));
            v = sat16(longint'(samples[i]) - 2 * h1 - 3 * h2 - 4 * h3);
            gold[i] = v;
            h3 = h2; h2 = h1; h1 = v;
        end
        sent = 0; recv = 0; overlap = 0; guard = 0;
        while (recv < 20 && guard < 2000) begin
            if (in_ready && out_valid) overlap = 1;
            in_valid = (sent < 20);
            x_in     = samples[(sent < 20) ? sent : 19];
            if (in_valid && in_ready) sent++;
            out_ready = 1'($urandom_range(0, 1));
            if (out_valid && out_ready) begin
                check($sformatf("b2b_y%0d", recv), y_out, gold[recv]);
                recv++;
            end
            @(negedge clk);
            guard++;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        check("b2b_received", recv, 20);
        check("b2b_no_overlap", overlap, 0);
        stable = 1;
        repeat (10) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stable = 0;
        end
        check("b2b_no_extra_output", stable, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
